// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial WIDTH-bit adder with start/busy/done handshake.
//
// Feeds one operand bit pair per clock (LSB first) into a 1-bit full adder
// cell. It registers each sum bit and feeds the carry-out back in. The full
// result is published only on the completion edge.
//
// Parameters:
//   WIDTH  operand/result width, 2..32
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  launch request, accepted in IDLE or DONE
//   a, b   operands, captured on an accepted start
//   cin    initial carry-in, captured on an accepted start
//   busy   high while bits are being processed
//   done   one-cycle completion pulse
//   sum    registered result, held until the next completion
//   cout   registered final carry-out, held like sum
//   ovf    (only with SERIAL_ADDER_CTRL_OVF_EN) two's-complement overflow
//
// Optional feature macro: SERIAL_ADDER_CTRL_OVF_EN adds the ovf output.

module fulladd (
  input  logic x,
  input  logic y,
  input  logic Cin,
  output logic s,
  output logic Cout
);
  assign s    = x ^ y ^ Cin;
  assign Cout = (x & y) | (Cin & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);
  // One extra bit so the counter cannot wrap before reaching WIDTH.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             load, last;

  fulladd u_fa (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .Cin (carry),
    .s   (fa_s),
    .Cout(fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // load: capture operands this edge; last: this edge processes the MSB.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {fa_s, res_sh[WIDTH-1:1]};
        carry  <= fa_co;
        cnt    <= cnt + CW'(1);
      end
      // The final sum bit has not landed in res_sh yet, so merge it here.
      if (last) begin
        sum  <= {fa_s, res_sh[WIDTH-1:1]};
        cout <= fa_co;
      end
    end
  end

`ifdef SERIAL_ADDER_CTRL_OVF_EN
  // On the last bit, carry holds the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf <= 1'b0;
    else if (last) ovf <= carry ^ fa_co;
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_CTRL_OVF_EN
  logic         ovf;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_CTRL_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    int   ux, uy, sx, sy, ut, st;
    ux = int'(x); uy = int'(y);
    sx = (ux >= (1 << (W-1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W-1))) ? uy - (1 << W) : uy;
    ut = ux + uy + int'(c);
    st = sx + sy + int'(c);
    e.sum  = W'(ut % (1 << W));
    e.cout = (ut >= (1 << W));
    e.ovf  = (st > (1 << (W-1)) - 1) || (st < -(1 << (W-1)));
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops expected results on done and polices output stability.
  int           busy_run = 0;
  logic         prev_done = 1'b0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
      last_sum  = '0;
      last_cout = 1'b0;
    end else begin
      if (!done) begin
        chk("sum_hold", int'({cout, sum}), int'({last_cout, last_sum}));
      end
      if (busy) busy_run++;
      if (done) begin
        chk("double_done", int'(prev_done), 0);
        chk("busy_cycles", busy_run, W);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", int'(sum), int'(e.sum));
          chk("cout", int'(cout), int'(e.cout));
`ifdef SERIAL_ADDER_CTRL_OVF_EN
          chk("ovf", int'(ovf), int'(e.ovf));
`endif
        end
        last_sum  = sum;
        last_cout = cout;
        busy_run  = 0;
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) chk("done_timeout", 1, 0);
  endtask

  // One-cycle start; expectation queued only if the op should complete.
  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit push);
    a = x; b = y; cin = c; start = 1'b1;
    if (push) exp_q.push_back(model(x, y, c));
    tick();
    start = 1'b0;
  endtask

  task automatic check_clear(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_sum"},  int'(sum), 0);
    chk({tag, "_cout"}, int'(cout), 0);
  endtask

  initial begin
    // Reset held for two cycles.
    rst = 1'b1;
    tick(); tick();
    check_clear("rst");
    rst = 1'b0;
    tick();

    // Basic directed cases.
    go(8'h0F, 8'h01, 1'b0, 1);
    chk("busy_after_start", int'(busy), 1);
    wait_idle(); tick();
    go(8'hFF, 8'h01, 1'b0, 1); wait_idle(); tick();
    go(8'hFF, 8'hFF, 1'b1, 1); wait_idle(); tick();
    go(8'h7F, 8'h01, 1'b0, 1); wait_idle(); tick();
    chk("sum_7f", int'(sum), 8'h80);

    // Reset applied between edges clears outputs immediately.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_clear("async_rst");
    tick();
    rst = 1'b0;
    tick();

    // Start during SHIFT is ignored.
    go(8'h12, 8'h34, 1'b0, 1);
    tick(); tick();
    a = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    chk("ignored_start_sum", int'(sum), 8'h46);

    // Start during DONE launches the next op immediately.
    go(8'h80, 8'h80, 1'b1, 1);
    chk("b2b_busy", int'(busy), 1);
    wait_idle(); tick();

    // Abort mid-operation: no done for the aborted op.
    go(8'hAA, 8'h55, 1'b0, 0);
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check_clear("abort");
    tick();
    rst = 1'b0;
    tick();
    go(8'hAA, 8'h55, 1'b0, 1); wait_idle(); tick();
    chk("after_abort_sum", int'(sum), 8'hFF);

    // Randomized traffic, mixing idle gaps with back-to-back launches.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      logic         c;
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom);
      if ($urandom_range(0, 1) == 1) wait_done();
      else begin wait_idle(); repeat ($urandom_range(0, 2)) tick(); end
      go(x, y, c, 1);
    end
    wait_idle();
    tick(); tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
